systolic_feeder: RTL and testbench

//  Operand source for the N x N array of `element` MAC PEs. Each job is k_len operand-vector pairs.

---
 rtl/cnn_pkg.sv | 15 +
 rtl/skew_line.sv | 25 ++
 rtl/systolic_feeder.sv | 100 ++++++++++
 tb/tb_systolic_feeder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the systolic feeder: FSM state codes and the flush-length helper.
package cnn_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] FEED  = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  // Zero cycles needed after the last accept for it to reach the far corner PE.
  function automatic int unsigned flush_cycles(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/skew_line.sv
// DEPTH-stage shift register for one operand lane; synchronous active-high reset clears every stage.
module skew_line #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout
);

  logic [DATA_SIZE-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= din;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Operand source for an N x N MAC array: clears the PEs, feeds skewed A/B lanes, flushes, flags done.
module systolic_feeder
  import cnn_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int N         = 4,
  parameter int KW        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DATA_SIZE-1:0] in_a_vec,
  input  logic [N*DATA_SIZE-1:0] in_b_vec,
  output logic [N*DATA_SIZE-1:0] out_a,
  output logic [N*DATA_SIZE-1:0] out_b,
  output logic                   pe_clear,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned FLUSH_CYCLES = flush_cycles(N);
  localparam int          FCW          = $clog2(FLUSH_CYCLES + 1);

  logic [2:0]             state, state_next;
  logic [KW-1:0]          k_len_q;
  logic [KW-1:0]          acc_cnt;
  logic [FCW-1:0]         flush_cnt;
  logic                   accept, last_accept, flush_last;
  logic [N*DATA_SIZE-1:0] feed_a, feed_b;

  assign accept      = in_ready && in_valid;
  assign last_accept = accept && (acc_cnt == k_len_q - KW'(1));
  assign flush_last  = (flush_cnt == FCW'(FLUSH_CYCLES - 1));
  assign busy        = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = (k_len_q == '0) ? DONE : FEED;
      FEED:    if (last_accept) state_next = FLUSH;
      FLUSH:   if (flush_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs are flopped from the next state so they carry no combinational input paths.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k_len_q   <= '0;
      acc_cnt   <= '0;
      flush_cnt <= '0;
      in_ready  <= 1'b0;
      pe_clear  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == FEED);
      pe_clear <= (state_next == CLEAR);
      done     <= (state_next == DONE);
      if (state == IDLE && start) k_len_q <= k_len;
      if (state == CLEAR)  acc_cnt <= '0;
      else if (accept)     acc_cnt <= acc_cnt + KW'(1);
      if (state == FLUSH)  flush_cnt <= flush_cnt + FCW'(1);
      else                 flush_cnt <= '0;
    end
  end

  // Bubbles and every non-FEED cycle push zeros so idle lanes add nothing to the PEs.
  assign feed_a = accept ? in_a_vec : '0;
  assign feed_b = accept ? in_b_vec : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(
      .DATA_SIZE(DATA_SIZE),
      .DEPTH    (i + 1)
    ) u_skew_a (
      .clk  (clk),
      .reset(reset),
      .din  (feed_a[i*DATA_SIZE +: DATA_SIZE]),
      .dout (out_a[i*DATA_SIZE +: DATA_SIZE])
    );

    skew_line #(
      .DATA_SIZE(DATA_SIZE),
      .DEPTH    (i + 1)
    ) u_skew_b (
      .clk  (clk),
      .reset(reset),
      .din  (feed_b[i*DATA_SIZE +: DATA_SIZE]),
      .dout (out_b[i*DATA_SIZE +: DATA_SIZE])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: drives directed jobs into a modelled PE array and checks lanes and C = A*B.
module tb_systolic_feeder;

  localparam int DS = 8;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int W  = N * DS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a_vec = '0;
  logic [W-1:0]  in_b_vec = '0;
  logic [W-1:0]  out_a, out_b;
  logic          pe_clear, busy, done;

  systolic_feeder #(.DATA_SIZE(DS), .N(N), .KW(KW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .k_len   (k_len),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a_vec(in_a_vec),
    .in_b_vec(in_b_vec),
    .out_a   (out_a),
    .out_b   (out_b),
    .pe_clear(pe_clear),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int ecount = 0;
  int last_rst = 0;
  int ndone = 0;
  logic [W-1:0] hist_a [4096];
  logic [W-1:0] hist_b [4096];
  logic [W-1:0] ja [16];
  logic [W-1:0] jb [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  // Record what the bench offered at each edge; only offered-and-valid vectors enter the array.
  always @(posedge clk) begin
    ecount = ecount + 1;
    if (ecount > 4000) begin
      $display("FAIL edge_budget: got %0d expected below 4000", ecount);
      $fatal(1);
    end
    if (reset) last_rst = ecount;
    hist_a[ecount] = in_valid ? in_a_vec : '0;
    hist_b[ecount] = in_valid ? in_b_vec : '0;
  end

  // Lane i shows, in the cycle after edge e, the vector accepted at edge e-i.
  always @(negedge clk) begin
    logic [W-1:0] ea, eb;
    ea = '0;
    eb = '0;
    for (int i = 0; i < N; i++) begin
      if (ecount - i > last_rst) begin
        ea[i*DS +: DS] = hist_a[ecount-i][i*DS +: DS];
        eb[i*DS +: DS] = hist_b[ecount-i][i*DS +: DS];
      end
    end
    check("out_a_lanes", out_a, ea);
    check("out_b_lanes", out_b, eb);
    if (done === 1'b1) ndone++;
  end

  // Behavioural N x N MAC array; wide accumulators keep the reference comparison exact.
  logic [DS-1:0] pa [N][N];
  logic [DS-1:0] pb [N][N];
  logic [31:0]   acc [N][N];

  always @(posedge clk) begin
    logic [DS-1:0] ain, bin;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ain = (j == 0) ? out_a[i*DS +: DS] : pa[i][j-1];
        bin = (i == 0) ? out_b[j*DS +: DS] : pb[i-1][j];
        if (reset || pe_clear) begin
          acc[i][j] <= '0;
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + 32'(ain) * 32'(bin);
          pa[i][j]  <= ain;
          pb[i][j]  <= bin;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job; returns in the done cycle with rel = done edge minus start edge.
  task automatic run_job(input int k, input logic [15:0] pat, input int plen, input bit poke,
                         output int rel);
    int s, last_acc, vi, got;
    start = 1'b1;
    k_len = KW'(k);
    tick();
    s = ecount;
    start = 1'b0;
    k_len = KW'(k + 5);
    check("pe_clear_on", pe_clear, 1);
    check("busy_clear", busy, 1);
    check("ready_clear", in_ready, 0);
    tick();
    vi = 0;
    last_acc = s;
    for (int p = 0; p < plen; p++) begin
      in_valid = pat[p];
      if (pat[p]) begin
        in_a_vec = ja[vi];
        in_b_vec = jb[vi];
        vi++;
      end else begin
        in_a_vec = 32'hA5A5_5A5A;
        in_b_vec = 32'h5A5A_A5A5;
      end
      check("ready_feed", in_ready, 1);
      start = poke && (p == 1);
      tick();
      start = 1'b0;
      if (pat[p]) last_acc = ecount;
    end
    in_valid = 1'b0;
    in_a_vec = '0;
    in_b_vec = '0;
    got = -1;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        got = ecount;
        break;
      end
      check("ready_flush", in_ready, 0);
      start = poke && (c == 2);
      tick();
      start = 1'b0;
    end
    check("done_time", got, (k == 0) ? s + 1 : last_acc + 2 * N - 1);
    check("ready_done", in_ready, 0);
    rel = got - s;
    if (got >= 0) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          int sum;
          sum = 0;
          for (int v = 0; v < k; v++)
            sum += int'(ja[v][i*DS +: DS]) * int'(jb[v][j*DS +: DS]);
          check("out_c_ref", acc[i][j], sum);
        end
      end
    end
  endtask

  task automatic finish_job();
    tick();
    check("done_drop", done, 0);
    check("busy_drop", busy, 0);
  endtask

  initial begin
    int r1, r2, r3a, r3b, r4, r5, r6, nd0;
    repeat (3) tick();
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_ready", in_ready, 0);
    check("rst_clear", pe_clear, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    tick();

    // 1) identity operands, gap-free
    for (int v = 0; v < N; v++) begin
      ja[v] = '0;
      jb[v] = '0;
      ja[v][v*DS +: DS] = 8'd1;
      jb[v][v*DS +: DS] = 8'd1;
    end
    run_job(4, 16'h000F, 4, 1'b0, r1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) check("ident_c", acc[i][j], (i == j) ? 1 : 0);
    finish_job();

    // 2) all-ones bytes, three vectors
    for (int v = 0; v < 3; v++) begin
      ja[v] = {N{8'hFF}};
      jb[v] = {N{8'hFF}};
    end
    run_job(3, 16'h0007, 3, 1'b0, r2);
    check("ff_c00", acc[0][0], 195075);
    check("ff_c33", acc[3][3], 195075);
    finish_job();

    // 3) same data gap-free and with bubbles 1,0,0,1,1,0,1
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < N; i++) begin
        ja[v][i*DS +: DS] = 8'((v * 4 + i + 1) * 3);
        jb[v][i*DS +: DS] = 8'(v + 2 * i + 1);
      end
    end
    run_job(4, 16'h000F, 4, 1'b0, r3a);
    finish_job();
    run_job(4, 16'h0059, 7, 1'b0, r3b);
    finish_job();
    check("bubble_delay", r3b - r3a, 3);
    check("gapfree_rel", r3a, r1);

    // 4) empty job
    run_job(0, 16'h0000, 0, 1'b0, r4);
    check("k0_c", acc[2][1], 0);
    check("k0_rel", r4, 1);
    finish_job();

    // 5) reset after two accepts aborts the job
    start = 1'b1;
    k_len = 8'd4;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1;
    in_a_vec = 32'h0403_0201;
    in_b_vec = 32'h0807_0605;
    tick();
    in_a_vec = 32'h1111_1111;
    tick();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    check("abort_out_a", out_a, 0);
    check("abort_out_b", out_b, 0);
    check("abort_ready", in_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_clear", pe_clear, 0);
    check("abort_done", done, 0);
    reset = 1'b0;
    nd0 = ndone;
    repeat (12) tick();
    check("abort_no_done", ndone - nd0, 0);
    run_job(4, 16'h000F, 4, 1'b0, r5);
    finish_job();

    // 6) start pulses during FEED and FLUSH are ignored
    nd0 = ndone;
    run_job(3, 16'h0007, 3, 1'b1, r6);
    finish_job();
    repeat (10) tick();
    check("poke_one_done", ndone - nd0, 1);
    check("poke_rel", r6, r2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
